// File: rtl/mem_arbiter.sv
// Two-port valid/ready arbiter sequencing one 256x8 memory op at a time; write 2 cycles, read 3 (rvalid at E+2).
// gnt only in IDLE, no queueing; tie-break is fixed port 0 unless MEM_ARB_RR_EN selects round-robin.
module mem_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic              busy,
   output logic              ce_mem,
   output logic              we_mem,
   output logic [ADDR_W-1:0] addr_mem,
   output logic [DATA_W-1:0] datai_mem,
   input  logic [DATA_W-1:0] datao_mem
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   state_t state, state_nxt;
   logic   owner;
   logic   hs0, hs1;
   req_t   sel;

`ifdef MEM_ARB_RR_EN
   logic rr_ptr;

   // Pointer names the port preferred on the next tie: the one just passed over.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rr_ptr <= 1'b0;
      else if (hs0 || hs1)
         rr_ptr <= hs0;
   end
`endif

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state == IDLE) begin
         if (req0 && req1) begin
`ifdef MEM_ARB_RR_EN
            gnt0 = ~rr_ptr;
            gnt1 = rr_ptr;
`else
            gnt0 = 1'b1;
`endif
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   assign hs0  = req0 && gnt0;
   assign hs1  = req1 && gnt1;
   assign sel  = hs1 ? req_t'{we1, addr1, wdata1} : req_t'{we0, addr0, wdata0};
   assign busy = (state != IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (hs0 || hs1) state_nxt = ISSUE;
         ISSUE:   state_nxt = we_mem ? IDLE : WAIT;
         WAIT:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // ce/we are a single-cycle strobe; addr/data are left holding after the op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ce_mem    <= 1'b0;
         we_mem    <= 1'b0;
         addr_mem  <= '0;
         datai_mem <= '0;
         owner     <= 1'b0;
      end else begin
         ce_mem <= 1'b0;
         we_mem <= 1'b0;
         if (hs0 || hs1) begin
            ce_mem    <= 1'b1;
            we_mem    <= sel.we;
            addr_mem  <= sel.addr;
            datai_mem <= sel.wdata;
            owner     <= hs1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rdata0  <= '0;
         rdata1  <= '0;
      end else begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         if (state == WAIT) begin
            if (owner) begin
               rdata1  <= datao_mem;
               rvalid1 <= 1'b1;
            end else begin
               rdata0  <= datao_mem;
               rvalid0 <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous 256x8 memory model; tie checks follow MEM_ARB_RR_EN.
module tb_mem_arbiter;

   logic       clk, rst_n;
   logic       req0, req1, we0, we1;
   logic [7:0] addr0, addr1, wdata0, wdata1;
   logic       gnt0, gnt1, rvalid0, rvalid1;
   logic [7:0] rdata0, rdata1;
   logic       busy, ce_mem, we_mem;
   logic [7:0] addr_mem, datai_mem, datao_mem;
   logic [7:0] mem [256];
   int         n_checks = 0;
   int         n_fail   = 0;
   logic       watch_g1 = 1'b0;
   logic       seen_g1  = 1'b0;

   mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1),
      .rvalid0(rvalid0), .rdata0(rdata0), .rvalid1(rvalid1), .rdata1(rdata1),
      .busy(busy), .ce_mem(ce_mem), .we_mem(we_mem),
      .addr_mem(addr_mem), .datai_mem(datai_mem), .datao_mem(datao_mem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous memory: read data appears the cycle after the op is issued.
   always @(posedge clk) begin
      if (ce_mem) begin
         if (we_mem) mem[addr_mem] <= datai_mem;
         else        datao_mem     <= mem[addr_mem];
      end
   end

   always @(negedge clk) if (watch_g1 && gnt1) seen_g1 = 1'b1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int port, input logic we, input logic [7:0] a, input logic [7:0] d);
      if (port == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
      else           begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
   endtask

   task automatic drop(input int port);
      if (port == 0) req0 = 1'b0; else req1 = 1'b0;
   endtask

   // Waits (bounded) for the port's gnt, then returns 1 ns after the handshake edge.
   task automatic handshake(input int port, input string tag);
      int   n = 0;
      logic g;
      @(negedge clk); #1;
      g = (port == 0) ? gnt0 : gnt1;
      while (!g && n < 20) begin
         @(negedge clk); #1;
         g = (port == 0) ? gnt0 : gnt1;
         n++;
      end
      check({tag, "_gnt"}, g, 1);
      @(posedge clk); #1;
   endtask

   task automatic do_write(input int port, input logic [7:0] a, input logic [7:0] d, input string tag);
      set_req(port, 1'b1, a, d);
      handshake(port, tag);
      drop(port);
      @(posedge clk); #1;
   endtask

   task automatic do_read(input int port, input logic [7:0] a, input logic [7:0] exp, input string tag);
      set_req(port, 1'b0, a, 8'h00);
      handshake(port, tag);
      drop(port);
      @(posedge clk);
      @(posedge clk); #1;
      check({tag, "_rvalid"}, (port == 0) ? rvalid0 : rvalid1, 1);
      check({tag, "_rdata"},  (port == 0) ? rdata0  : rdata1,  exp);
   endtask

   initial begin
      int who, exp_who, n;
      rst_n = 1'b0;
      req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
      req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_gnt0", gnt0, 0);      check("rst_gnt1", gnt1, 0);
      check("rst_busy", busy, 0);      check("rst_ce", ce_mem, 0);
      check("rst_we", we_mem, 0);      check("rst_addr", addr_mem, 0);
      check("rst_datai", datai_mem, 0);
      check("rst_rvalid0", rvalid0, 0); check("rst_rvalid1", rvalid1, 0);
      check("rst_rdata0", rdata0, 0);  check("rst_rdata1", rdata1, 0);
      @(negedge clk) rst_n = 1'b1;

      // Single write then read on port 0
      set_req(0, 1'b1, 8'h3C, 8'hA5);
      handshake(0, "t1_wr");
      check("t1_ce", ce_mem, 1);       check("t1_we", we_mem, 1);
      check("t1_addr", addr_mem, 8'h3C); check("t1_datai", datai_mem, 8'hA5);
      check("t1_busy", busy, 1);
      drop(0);
      @(posedge clk); #1;
      check("t1_ce_clr", ce_mem, 0);   check("t1_we_clr", we_mem, 0);
      check("t1_idle", busy, 0);       check("t1_addr_hold", addr_mem, 8'h3C);
      check("t1_mem", mem[8'h3C], 8'hA5);
      set_req(0, 1'b0, 8'h3C, 8'h00);
      handshake(0, "t1_rd");
      drop(0);
      check("t1_rd_ce", ce_mem, 1);    check("t1_rd_we", we_mem, 0);
      @(posedge clk); #1;
      check("t1_wait_ce", ce_mem, 0);  check("t1_wait_busy", busy, 1);
      check("t1_wait_rv", rvalid0, 0);
      @(posedge clk); #1;
      check("t1_rv0", rvalid0, 1);     check("t1_rd0", rdata0, 8'hA5);
      check("t1_rv1", rvalid1, 0);     check("t1_rd1", rdata1, 0);
      check("t1_busy_end", busy, 0);
      @(posedge clk); #1;
      check("t1_rv0_pulse", rvalid0, 0); check("t1_rd0_hold", rdata0, 8'hA5);

      // Simultaneous reads
      do_write(0, 8'h10, 8'h11, "pre0");
      do_write(1, 8'h20, 8'h22, "pre1");
      set_req(0, 1'b0, 8'h10, 8'h00);
      set_req(1, 1'b0, 8'h20, 8'h00);
      watch_g1 = 1'b1;
      for (int g = 0; g < 4; g++) begin
         n = 0;
         @(negedge clk); #1;
         while (!(gnt0 || gnt1) && n < 20) begin @(negedge clk); #1; n++; end
         who = gnt1 ? 1 : 0;
`ifdef MEM_ARB_RR_EN
         exp_who = g % 2;
`else
         exp_who = 0;
`endif
         check("tie_both", {31'd0, gnt0 & gnt1}, 0);
         check("tie_who", who, exp_who);
         @(posedge clk);
         @(posedge clk);
         @(posedge clk); #1;
         check("tie_rv", (who == 1) ? rvalid1 : rvalid0, 1);
         check("tie_rd", (who == 1) ? rdata1 : rdata0, (who == 1) ? 8'h22 : 8'h11);
      end
      watch_g1 = 1'b0;
`ifndef MEM_ARB_RR_EN
      check("fixed_no_gnt1", seen_g1, 0);
`endif
      drop(0);
      @(negedge clk); #1;
      check("drop0_gnt1", gnt1, 1);    check("drop0_gnt0", gnt0, 0);
      @(posedge clk); #1;
      drop(1);
      @(posedge clk);
      @(posedge clk); #1;
      check("drop0_rv1", rvalid1, 1);  check("drop0_rd1", rdata1, 8'h22);

      // Cross-port coherence at the top address
      do_write(1, 8'hFF, 8'h5A, "x_wr");
      check("x_mem", mem[8'hFF], 8'h5A);
      do_read(0, 8'hFF, 8'h5A, "x_rd");
      check("x_rd1_keep", rdata1, 8'h22);

      // Back-to-back writes from port 1
      @(negedge clk);
      set_req(1, 1'b1, 8'h80, 8'hC0);
      for (int i = 0; i < 8; i++) begin
         #1;
         check("b2b_gnt_hi", gnt1, 1);  check("b2b_idle", busy, 0);
         @(posedge clk); #1;
         if (i < 7) set_req(1, 1'b1, 8'h80 + 8'(i + 1), 8'hC0 + 8'(i + 1));
         else       drop(1);
         @(negedge clk); #1;
         check("b2b_gnt_lo", gnt1, 0);  check("b2b_issue_busy", busy, 1);
         @(negedge clk);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) do_read(0, 8'h80 + 8'(i), 8'hC0 + 8'(i), "b2b_rd");

      // Reset asserted during WAIT
      set_req(0, 1'b0, 8'h3C, 8'h00);
      handshake(0, "rst_rd");
      drop(0);
      @(posedge clk); #1;
      check("rstw_in_wait", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rstw_ce", ce_mem, 0);     check("rstw_we", we_mem, 0);
      check("rstw_addr", addr_mem, 0); check("rstw_datai", datai_mem, 0);
      check("rstw_busy", busy, 0);     check("rstw_rv0", rvalid0, 0);
      check("rstw_rd0", rdata0, 0);    check("rstw_rd1", rdata1, 0);
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("rstw_no_rv0", rvalid0, 0);
      end
      do_read(0, 8'h3C, 8'hA5, "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
